// File: rtl/osc_voice_alloc.sv
// Voice allocator and scheduler for the oscillator bank.
// Accepts note-on/note-off events over a valid/ready handshake. Each note goes to one of
// VOICES oscillators. When every voice is busy, the oldest voice is stolen.
// An event takes three cycles: IDLE (handshake), LOOKUP (search), then APPLY (commit).
//
// Ports:
//   clk_i, nrst_i    clock; asynchronous active-low reset
//   evValid_i        event valid
//   evOn_i           event type: 1 = note-on, 0 = note-off
//   evNote_i         note code of the event
//   evReady_o        allocator can accept an event
//   voiceActive_o    per-voice active mask
//   voiceNote_o      note code of voice k at [k*NOTE_BW +: NOTE_BW]
//   voiceLoad_o      one-cycle strobe: voice k reloads phase and note
//   steal_o          one-cycle pulse when an active voice was stolen
//   sustain_i        sustain pedal (only with OSC_VOICE_ALLOC_SUSTAIN_EN)
//
// Optional feature macro: OSC_VOICE_ALLOC_SUSTAIN_EN. When it is defined, a note-off that
// arrives while the sustain pedal is down marks the voice as held. The falling edge of the
// pedal then releases all held voices together.

`ifndef OSC_VOICES
`define OSC_VOICES 7
`endif

module osc_voice_alloc #(
  parameter int unsigned VOICES  = `OSC_VOICES,
  parameter int unsigned NOTE_BW = 7,
  parameter int unsigned AGE_BW  = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                      clk_i,
  input  logic                      nrst_i,
  input  logic                      evValid_i,
  input  logic                      evOn_i,
  input  logic [NOTE_BW-1:0]        evNote_i,
`ifdef OSC_VOICE_ALLOC_SUSTAIN_EN
  input  logic                      sustain_i,
`endif
  output logic                      evReady_o,
  output logic [VOICES-1:0]         voiceActive_o,
  output logic [VOICES*NOTE_BW-1:0] voiceNote_o,
  output logic [VOICES-1:0]         voiceLoad_o,
  output logic                      steal_o
);

  localparam int unsigned IdxBw = AGE_BW;
  localparam logic [AGE_BW-1:0] AgeMax = AGE_BW'(VOICES - 1);

  typedef enum logic [1:0] {StIdle, StLookup, StApply} stateT;

  stateT                stateQ, stateD;
  logic                 evOnQ, evOnD;
  logic [NOTE_BW-1:0]   evNoteQ, evNoteD;
  logic                 matchFoundQ, matchFoundD, freeFoundQ, freeFoundD;
  logic [IdxBw-1:0]     matchIdxQ, matchIdxD, freeIdxQ, freeIdxD, oldestIdxQ, oldestIdxD;
  logic [VOICES-1:0]    activeQ, activeD;
  logic [NOTE_BW-1:0]   noteQ [VOICES];
  logic [NOTE_BW-1:0]   noteD [VOICES];
  logic [AGE_BW-1:0]    ageQ [VOICES];
  logic [AGE_BW-1:0]    ageD [VOICES];
  logic [VOICES-1:0]    loadQ, loadD;
  logic                 stealQ, stealD;

  // Search results computed combinationally from current state, captured in LOOKUP.
  logic                 matchFound, freeFound;
  logic [IdxBw-1:0]     matchIdx, freeIdx, oldestIdx, tgtIdx;
  logic [AGE_BW-1:0]    oldestAge;

`ifdef OSC_VOICE_ALLOC_SUSTAIN_EN
  logic [VOICES-1:0]    heldQ, heldD;
  logic                 sustainQ, pendingQ, pendingD;
  logic                 sustainFall;
  assign sustainFall = sustainQ & ~sustain_i;
`endif

  always_comb begin
    matchFound = 1'b0;
    matchIdx   = '0;
    freeFound  = 1'b0;
    freeIdx    = '0;
    oldestIdx  = '0;
    oldestAge  = '0;
    for (int k = 0; k < VOICES; k++) begin
      if (activeQ[k] && (noteQ[k] == evNoteQ) && !matchFound) begin
        matchFound = 1'b1;
        matchIdx   = IdxBw'(k);
      end
      if (!activeQ[k] && !freeFound) begin
        freeFound = 1'b1;
        freeIdx   = IdxBw'(k);
      end
      // Strictly greater keeps the lowest index on ties.
      if (ageQ[k] > oldestAge) begin
        oldestAge = ageQ[k];
        oldestIdx = IdxBw'(k);
      end
    end
  end

  always_comb begin
    stateD      = stateQ;
    evOnD       = evOnQ;
    evNoteD     = evNoteQ;
    matchFoundD = matchFoundQ;
    matchIdxD   = matchIdxQ;
    freeFoundD  = freeFoundQ;
    freeIdxD    = freeIdxQ;
    oldestIdxD  = oldestIdxQ;
    activeD     = activeQ;
    noteD       = noteQ;
    ageD        = ageQ;
    loadD       = '0;
    stealD      = 1'b0;
    evReady_o   = 1'b0;
    tgtIdx      = '0;
`ifdef OSC_VOICE_ALLOC_SUSTAIN_EN
    heldD       = heldQ;
    pendingD    = pendingQ | sustainFall;
`endif
    case (stateQ)
      StIdle: begin
`ifdef OSC_VOICE_ALLOC_SUSTAIN_EN
        if (pendingQ) begin
          // Pedal released: drop every held voice before taking a new event.
          pendingD = sustainFall;
          for (int k = 0; k < VOICES; k++) begin
            if (heldQ[k]) begin
              activeD[k] = 1'b0;
              noteD[k]   = '0;
              ageD[k]    = '0;
              heldD[k]   = 1'b0;
            end
          end
        end else
`endif
        begin
          evReady_o = 1'b1;
          if (evValid_i) begin
            evOnD   = evOn_i;
            evNoteD = evNote_i;
            stateD  = StLookup;
          end
        end
      end
      StLookup: begin
        matchFoundD = matchFound;
        matchIdxD   = matchIdx;
        freeFoundD  = freeFound;
        freeIdxD    = freeIdx;
        oldestIdxD  = oldestIdx;
        stateD      = StApply;
      end
      StApply: begin
        stateD = StIdle;
        if (evOnQ) begin
          tgtIdx = matchFoundQ ? matchIdxQ : (freeFoundQ ? freeIdxQ : oldestIdxQ);
          for (int k = 0; k < VOICES; k++) begin
            if (activeQ[k] && (IdxBw'(k) != tgtIdx) && (ageQ[k] != AgeMax)) begin
              ageD[k] = ageQ[k] + 1'b1;
            end
          end
          activeD[tgtIdx] = 1'b1;
          noteD[tgtIdx]   = evNoteQ;
          ageD[tgtIdx]    = '0;
          loadD[tgtIdx]   = 1'b1;
          stealD          = !matchFoundQ && !freeFoundQ;
`ifdef OSC_VOICE_ALLOC_SUSTAIN_EN
          heldD[tgtIdx]   = 1'b0;
`endif
        end else if (matchFoundQ) begin
`ifdef OSC_VOICE_ALLOC_SUSTAIN_EN
          if (sustain_i) begin
            heldD[matchIdxQ] = 1'b1;
          end else begin
            activeD[matchIdxQ] = 1'b0;
            noteD[matchIdxQ]   = '0;
            ageD[matchIdxQ]    = '0;
            heldD[matchIdxQ]   = 1'b0;
          end
`else
          activeD[matchIdxQ] = 1'b0;
          noteD[matchIdxQ]   = '0;
          ageD[matchIdxQ]    = '0;
`endif
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      stateQ      <= StIdle;
      evOnQ       <= 1'b0;
      evNoteQ     <= '0;
      matchFoundQ <= 1'b0;
      matchIdxQ   <= '0;
      freeFoundQ  <= 1'b0;
      freeIdxQ    <= '0;
      oldestIdxQ  <= '0;
      activeQ     <= '0;
      loadQ       <= '0;
      stealQ      <= 1'b0;
      for (int k = 0; k < VOICES; k++) begin
        noteQ[k] <= '0;
        ageQ[k]  <= '0;
      end
    end else begin
      stateQ      <= stateD;
      evOnQ       <= evOnD;
      evNoteQ     <= evNoteD;
      matchFoundQ <= matchFoundD;
      matchIdxQ   <= matchIdxD;
      freeFoundQ  <= freeFoundD;
      freeIdxQ    <= freeIdxD;
      oldestIdxQ  <= oldestIdxD;
      activeQ     <= activeD;
      loadQ       <= loadD;
      stealQ      <= stealD;
      noteQ       <= noteD;
      ageQ        <= ageD;
    end
  end

`ifdef OSC_VOICE_ALLOC_SUSTAIN_EN
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      heldQ    <= '0;
      sustainQ <= 1'b0;
      pendingQ <= 1'b0;
    end else begin
      heldQ    <= heldD;
      sustainQ <= sustain_i;
      pendingQ <= pendingD;
    end
  end
`endif

  always_comb begin
    voiceNote_o = '0;
    for (int k = 0; k < VOICES; k++) begin
      voiceNote_o[k*NOTE_BW +: NOTE_BW] = noteQ[k];
    end
  end

  assign voiceActive_o = activeQ;
  assign voiceLoad_o   = loadQ;
  assign steal_o       = stealQ;

endmodule

// File: doc/osc_voice_alloc.md
Name: osc_voice_alloc

Overview:
- Voice allocator and scheduler for the oscillator bank.
- Accepts note-on/note-off events through a valid/ready handshake and assigns each note to one of VOICES oscillators, stealing the oldest voice when all are busy.
- Drives the per-voice active mask. Downstream, bitcount turns that mask into the active count that sets the pwm duty.
- Also emits per-voice note codes and a phase-reload strobe for the oscillators.

Parameters:
- VOICES, default `OSC_VOICES (7): number of oscillator voices managed.
- NOTE_BW, default 7: width of a note code.
- AGE_BW, default $clog2(VOICES): width of the per-voice age counter. Derived; do not override.

Ports:
- clk_i  input  1  system clock.
- nrst_i  input  1  reset; asynchronous, active-low.
- evValid_i  input  1  event valid.
- evOn_i  input  1  event type: 1 = note-on, 0 = note-off.
- evNote_i  input  NOTE_BW  note code of the event.
- evReady_o  output  1  allocator can accept an event.
- voiceActive_o  output  VOICES  active mask; bit k is set while voice k is sounding.
- voiceNote_o  output  VOICES*NOTE_BW  note of voice k at bits [k*NOTE_BW +: NOTE_BW].
- voiceLoad_o  output  VOICES  one-cycle strobe: voice k reloads phase and note.
- steal_o  output  1  one-cycle pulse when an active voice was stolen.

Behaviour:
- Reset, asynchronous: voiceActive_o=0, voiceNote_o=0, voiceLoad_o=0, steal_o=0, all ages=0, FSM=IDLE, evReady_o=1.
- FSM states:
  - IDLE: evReady_o=1. Handshake on evValid_i & evReady_o captures evOn_i and evNote_i, then goes to LOOKUP.
  - LOOKUP (1 cycle): evReady_o=0. Registers, from current state:
    - match index: active voice whose note equals the event note;
    - free index: lowest-index inactive voice;
    - oldest index: highest age, lowest index wins ties.
    - Then goes to APPLY.
  - APPLY (1 cycle): evReady_o=0. Commits the update and returns to IDLE.
- Latency: handshake in cycle N; voiceActive_o, voiceNote_o, voiceLoad_o and steal_o all change or pulse at the clock edge ending cycle N+2. Next event acceptable in cycle N+3. Throughput is one event per 3 cycles.
- Note-on with a match: retrigger. voiceLoad_o[match] pulses and its age is cleared. Mask is unchanged.
- Note-on, no match, free voice exists: voice[free] set active with the note, age 0, load pulse.
- Note-on, no match, no free voice: steal voice[oldest]. Note replaced, age 0, load pulse, steal_o pulse. Mask stays all ones.
- On every note-on commit, all other active voices increment age, saturating at VOICES-1.
- Note-off with a match: voice[match] cleared (active=0, note=0, age=0). No load pulse.
- Note-off without a match: no state change, no pulses.
- Invariant: no two active voices hold the same note. The retrigger rule guarantees this.
- Note code 0 is a legal note. Inactive voices never produce a match.
- evValid_i held high across events: a new event is taken at each IDLE cycle, i.e. every 3rd cycle.
- evNote_i and evOn_i are sampled only at the handshake. Changes while busy are ignored.
- Reset asserted mid-LOOKUP or mid-APPLY: event discarded, all state cleared, no strobe emitted.
- voiceLoad_o and steal_o are registered. They are high for exactly one cycle and never asserted outside APPLY commits.

Optional Feature:
- Macro: OSC_VOICE_ALLOC_SUSTAIN_EN.
- Defined:
  - Adds input sustain_i (1 bit) and a per-voice held flag.
  - Note-off with a match while sustain_i=1: voice stays active and its held flag is set.
  - Falling edge of sustain_i (registered edge detect, latched as pending): in the next IDLE cycle, before any new handshake, all held voices are cleared in one cycle, with evReady_o=0 during that cycle.
  - Note-on retriggering a held voice clears its held flag.
- Not defined: no sustain_i port, no held flags. Note-off always releases immediately.

Test Plan:
- Reset, then note-on 60: voiceActive_o=7'b0000001; voiceNote_o voice0=60; voiceLoad_o[0] pulses 2 cycles after handshake; bitcount yields 1.
- Note-ons 60,62,64,65,67,69,71, then note-on 72: all voices active; 72 steals voice0 (age 6); steal_o pulses; mask stays 7'h7F.
- Note-on 62 while 62 is active in voice1: retrigger; voiceLoad_o=7'b0000010; mask and ages of others unaffected except increment.
- Note-off 64 (voice2), then note-off 99 (absent): mask bit2 cleared; second event causes no change and no pulses; the next note-on 50 fills voice2.
- evValid_i held high with 3 queued events: evReady_o pattern 1,0,0 repeating; nrst_i dropped during APPLY clears all outputs immediately with no load pulse.
- With OSC_VOICE_ALLOC_SUSTAIN_EN: sustain_i=1, on 60, off 60 → voice0 stays active; sustain_i→0 → voice0 cleared within 2 cycles.
